// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller: registered scoreboard of in-flight writers driving
// load-use stall, ID bubble, IF/ID flush and EX forwarding selects.
// Optional counters enabled by defining PIPELINE_HAZARD_STATS_EN.
`timescale 1ns/1ps

module pipeline_hazard_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 2,
  parameter int BR_STAGE = 2,
  parameter int SEL_W    = $clog2(STAGES + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              branch_taken,
  output logic              stall,
  output logic              bubble,
  output logic              flush_ifid,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic [15:0]       stall_cycles,
  output logic [15:0]       flush_count
);

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic              ld;
    logic [ADDR_W-1:0] dest;
  } sb_entry_t;

  generate
    if (STAGES < 1) begin : g_bad_stages
      $error("pipeline_hazard_ctrl: STAGES must be at least 1");
    end
    if (LOAD_LAT < 1 || LOAD_LAT > STAGES) begin : g_bad_load_lat
      $error("pipeline_hazard_ctrl: LOAD_LAT must be in 1..STAGES");
    end
    if (BR_STAGE < 1 || BR_STAGE > STAGES) begin : g_bad_br_stage
      $error("pipeline_hazard_ctrl: BR_STAGE must be in 1..STAGES");
    end
  endgenerate

  sb_entry_t        sb_q [1:STAGES];
  sb_entry_t        sb_d [1:STAGES];
  logic [SEL_W-1:0] sel_a, sel_b;
  logic             ld_a, ld_b;
  logic             haz_a, haz_b;

  // Scan oldest to youngest so the youngest matching writer overrides.
  always_comb begin : match_logic
    // NOTE: every always_comb output gets a default first; a path that leaves one unassigned infers a latch.
    sel_a = '0;
    sel_b = '0;
    ld_a  = 1'b0;
    ld_b  = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (id_use_rs && (id_rs != '0) && sb_q[k].valid && sb_q[k].wr && (sb_q[k].dest == id_rs)) begin
        sel_a = SEL_W'(k);
        ld_a  = sb_q[k].ld;
      end
      if (id_use_rt && (id_rt != '0) && sb_q[k].valid && sb_q[k].wr && (sb_q[k].dest == id_rt)) begin
        sel_b = SEL_W'(k);
        ld_b  = sb_q[k].ld;
      end
    end
  end

  // A load still short of the stage that holds its data cannot be forwarded yet.
  assign haz_a = ld_a && (int'(sel_a) < LOAD_LAT);
  assign haz_b = ld_b && (int'(sel_b) < LOAD_LAT);

  assign stall      = id_valid && !branch_taken && (haz_a || haz_b);
  assign bubble     = stall || branch_taken;
  assign flush_ifid = branch_taken;
  assign fwd_a      = stall ? '0 : sel_a;
  assign fwd_b      = stall ? '0 : sel_b;

  always_comb begin : next_scoreboard
    for (int k = 1; k <= STAGES; k++) begin
      sb_d[k] = '0;
    end
    if (id_valid && !stall && !branch_taken) begin
      sb_d[1] = '{valid: 1'b1, wr: id_reg_write, ld: id_mem_read, dest: id_dest};
    end
    for (int k = 2; k <= STAGES; k++) begin
      sb_d[k] = sb_q[k-1];
    end
    // Slots up to the resolve stage would hold wrong-path instructions.
    if (branch_taken) begin
      for (int k = 1; k <= BR_STAGE; k++) begin
        sb_d[k].valid = 1'b0;
      end
    end
  end

  // NOTE: the scoreboard is a handful of flops whose valid bits gate all hazards, so it is cleared by reset, unlike a RAM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= STAGES; k++) begin
        sb_q[k] <= '0;
      end
    end else begin
      // NOTE: state registers use non-blocking assignment so every stage shifts from pre-edge values.
      for (int k = 1; k <= STAGES; k++) begin
        sb_q[k] <= sb_d[k];
      end
    end
  end

`ifdef PIPELINE_HAZARD_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (branch_taken && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
